// File: rtl/serial_compare_ctrl_if.sv
// serial_compare_ctrl_if
//   Groups the request side (start, operands, results) and the 1-bit
//   comparator side (bit_a/bit_b out, cmp_* back) of the serial compare
//   sequencer into one bundle.
//   slave  : the sequencer itself (serial_compare_ctrl).
//   master : the requester plus the attached 1-bit comparator.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             bit_a;
  logic             bit_b;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             a_greater_b;
  logic             a_equal_b;
  logic             a_lesser_b;
  logic             cmp_err;

  modport slave (
    input  start, a_in, b_in, cmp_gt, cmp_eq, cmp_lt,
    output busy, done, bit_a, bit_b,
           a_greater_b, a_equal_b, a_lesser_b, cmp_err
  );

  modport master (
    output start, a_in, b_in, cmp_gt, cmp_eq, cmp_lt,
    input  busy, done, bit_a, bit_b,
           a_greater_b, a_equal_b, a_lesser_b, cmp_err
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Sequencer for a shared 1-bit magnitude comparator. Latches two WIDTH-bit
//   operands on an accepted start, presents one bit pair per cycle MSB-first,
//   stops at the first unequal bit and reports a registered, one-hot
//   A>B / A==B / A<B result together with a one-cycle done pulse.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : serial_compare_ctrl_if.slave
//           start/a_in/b_in       request and operands (sampled in IDLE)
//           bit_a/bit_b           current bit pair to the comparator
//           cmp_gt/cmp_eq/cmp_lt  comparator answer for that bit pair
//           busy/done             SHIFT or DONE / one-cycle result strobe
//           a_greater_b/a_equal_b/a_lesser_b  result, held until next start
//           cmp_err               sticky: comparator answer was not one-hot
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_compare_ctrl_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when exactly one of the three comparator outputs is set.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;
  logic             bit_a_s, bit_b_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          idx_d   = IDX_MAX;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A malformed comparator answer aborts with "equal" so the result
        // flags stay one-hot; cmp_err tells the requester not to trust it.
        if (!is_onehot3({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt})) begin
          err_d   = 1'b1;
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else if (bus.cmp_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (bus.cmp_lt) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit pair to the comparator; parked at zero outside SHIFT.
  always_comb begin
    bit_a_s = 1'b0;
    bit_b_s = 1'b0;
    if (state_q == ST_SHIFT) begin
      bit_a_s = a_q[idx_q];
      bit_b_s = b_q[idx_q];
    end else begin
      bit_a_s = 1'b0;
      bit_b_s = 1'b0;
    end
  end

  assign bus.busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.bit_a       = bit_a_s;
  assign bus.bit_b       = bit_b_s;
  assign bus.a_greater_b = gt_q;
  assign bus.a_equal_b   = eq_q;
  assign bus.a_lesser_b  = lt_q;
  assign bus.cmp_err     = err_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl
//   Self-checking bench for serial_compare_ctrl (WIDTH=8) with a behavioural
//   1-bit comparator attached. Expected results come from integer magnitude
//   comparison and a first-differing-bit latency model.
module tb_serial_compare_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic force_bad = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  serial_compare_ctrl_if #(.WIDTH(W)) bus_if();

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // 1-bit comparator model, with an override that produces a bad answer.
  always_comb begin
    if (force_bad) begin
      bus_if.cmp_gt = 1'b1;
      bus_if.cmp_eq = 1'b1;
      bus_if.cmp_lt = 1'b0;
    end else begin
      bus_if.cmp_gt = bus_if.bit_a & ~bus_if.bit_b;
      bus_if.cmp_eq = (bus_if.bit_a == bus_if.bit_b);
      bus_if.cmp_lt = ~bus_if.bit_a & bus_if.bit_b;
    end
  end

  // Cycles from the accepting edge until done is seen.
  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return W - i + 1;
    end
    return W + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags3();
    return 32'({bus_if.a_greater_b, bus_if.a_equal_b, bus_if.a_lesser_b});
  endfunction

  // Full compare: start in IDLE, optional stray start at cycle icyc, checks
  // bit trace, latency, result, done pulse width and the IDLE that follows.
  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int icyc, input logic [W-1:0] ja,
                             input logic [W-1:0] jb);
    int lat;
    int n;
    logic [2:0] exp_f;
    lat   = ref_latency(a, b);
    exp_f = {a > b, a == b, a < b};
    bus_if.start = 1'b1;
    bus_if.a_in  = a;
    bus_if.b_in  = b;
    tick();
    bus_if.start = 1'b0;
    bus_if.a_in  = W'($urandom);
    bus_if.b_in  = W'($urandom);
    n = 1;
    check("accept_busy", 32'(bus_if.busy), 32'd1);
    check("accept_clear", 32'({flags3(), bus_if.cmp_err}), 32'd0);
    while (!bus_if.done && n < 40) begin
      if (n < lat && n <= W) begin
        check("bit_a", 32'(bus_if.bit_a), 32'(a[W-n]));
        check("bit_b", 32'(bus_if.bit_b), 32'(b[W-n]));
      end
      if (n == icyc) begin
        bus_if.start = 1'b1;
        bus_if.a_in  = ja;
        bus_if.b_in  = jb;
      end else begin
        bus_if.start = 1'b0;
      end
      tick();
      n++;
    end
    bus_if.start = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("done_busy", 32'(bus_if.busy), 32'd1);
    check("result", flags3(), 32'(exp_f));
    check("err_clean", 32'(bus_if.cmp_err), 32'd0);
    tick();
    check("done_pulse", 32'({bus_if.done, bus_if.busy}), 32'd0);
    check("idle_bits", 32'({bus_if.bit_a, bus_if.bit_b}), 32'd0);
    check("result_held", flags3(), 32'(exp_f));
  endtask

  initial begin
    int lat;
    int icyc;
    int mode;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a_in  = '0;
    bus_if.b_in  = '0;
    tick();
    tick();
    check("reset_outs", 32'({bus_if.busy, bus_if.done, bus_if.bit_a, bus_if.bit_b,
                             flags3(), bus_if.cmp_err}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'({bus_if.busy, bus_if.done}), 32'd0);

    // Directed cases.
    run_compare(8'hA5, 8'h25, 0, 8'h00, 8'h00);
    run_compare(8'h3C, 8'h3C, 0, 8'h00, 8'h00);
    run_compare(8'h40, 8'h41, 0, 8'h00, 8'h00);
    run_compare(8'h10, 8'h11, 3, 8'hFF, 8'h00);
    run_compare(8'hFF, 8'h00, 0, 8'h00, 8'h00);

    // Reset in cycle 4 of an equal compare: immediate clear, no done.
    bus_if.start = 1'b1;
    bus_if.a_in  = 8'h01;
    bus_if.b_in  = 8'h01;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset", 32'({bus_if.busy, bus_if.done, bus_if.bit_a, bus_if.bit_b,
                              flags3(), bus_if.cmp_err}), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_done_after_reset", 32'({bus_if.done, bus_if.busy}), 32'd0);
    end
    run_compare(8'h01, 8'h01, 0, 8'h00, 8'h00);

    // Non-one-hot comparator answer in the first SHIFT cycle.
    bus_if.start = 1'b1;
    bus_if.a_in  = 8'h5A;
    bus_if.b_in  = 8'h5A;
    tick();
    bus_if.start = 1'b0;
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    check("err_done", 32'(bus_if.done), 32'd1);
    check("err_flag", 32'(bus_if.cmp_err), 32'd1);
    check("err_result", flags3(), 32'b010);
    tick();
    check("err_sticky", 32'({bus_if.cmp_err, bus_if.done, bus_if.busy}), 32'b100);
    run_compare(8'h81, 8'h80, 0, 8'h00, 8'h00);

    // Randomised compares, some with stray start pulses while busy.
    for (int k = 0; k < 40; k++) begin
      ra   = W'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        rb = ra;
      end else if (mode == 1) begin
        rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      end else begin
        rb = W'($urandom);
      end
      lat  = ref_latency(ra, rb);
      icyc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 1) : 0;
      run_compare(ra, rb, icyc, W'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
